// File: rtl/mem_port_arbiter.sv
// Shares one word-wide, byte-laned memory port between instruction fetch and load/store.
// Round-robin arbitration, fixed-latency reads and read-modify-write for partial stores.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            i_req,
    input  logic [31:0]     i_addr,
    output logic [31:0]     i_rdata,
    output logic            i_ack,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [31:0]     d_addr,
    input  logic [31:0]     d_wdata,
    input  logic [3:0]      d_be,
    output logic [31:0]     d_rdata,
    output logic            d_ack,
    output logic [31:0]     mem_addr,
    output logic [0:3][7:0] mem_data_in,
    input  logic [0:3][7:0] mem_data_out,
    output logic            mem_write_en,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t      state, state_n;
    owner_t      owner, last_grant, grant, ack_owner;
    logic        grant_valid, grant_we, rd_done;
    logic [3:0]  lat_cnt;
    logic        lat_we;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic [31:0] rd_reg;

    // be[k] selects the new byte at word bits [8k+7:8k]; other bytes keep the memory value.
    function automatic logic [31:0] merge_word(input logic [31:0] wdata,
                                               input logic [3:0]  be,
                                               input logic [31:0] base);
        logic [31:0] m;
        for (int k = 0; k < 4; k++)
            m[8*k +: 8] = be[k] ? wdata[8*k +: 8] : base[8*k +: 8];
        return m;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_valid = i_req | d_req;
        grant       = OWN_I;
        if (d_req && (!i_req || last_grant == OWN_I))
            grant = OWN_D;
        grant_we    = (grant == OWN_D) && d_we;
        ack_owner   = (state == IDLE) ? grant : owner;
        rd_done     = (state == RD) && (lat_cnt == 4'd1);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (grant_valid) begin
                if (!grant_we)           state_n = RD;
                else if (d_be == 4'hF)   state_n = WR;
                else if (d_be == 4'h0)   state_n = RESP;
                else                     state_n = RD;
            end
            RD:      if (rd_done) state_n = lat_we ? WR : RESP;
            WR:      state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: all flops use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            owner        <= OWN_I;
            last_grant   <= OWN_I;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            mem_write_en <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            busy         <= 1'b0;
            lat_cnt      <= '0;
            lat_we       <= 1'b0;
            lat_wdata    <= '0;
            lat_be       <= '0;
            rd_reg       <= '0;
        end else begin
            // Status strobes are registered from the next state so they never glitch.
            mem_write_en <= (state_n == WR);
            busy         <= (state_n != IDLE);
            i_ack        <= (state_n == RESP) && (ack_owner == OWN_I);
            d_ack        <= (state_n == RESP) && (ack_owner == OWN_D);
            case (state)
                IDLE: if (grant_valid) begin
                    owner      <= grant;
                    last_grant <= grant;
                    mem_addr   <= ((grant == OWN_D) ? d_addr : i_addr) & 32'hFFFF_FFFC;
                    lat_we     <= grant_we;
                    lat_wdata  <= d_wdata;
                    lat_be     <= d_be;
                    lat_cnt    <= 4'(MEM_LATENCY);
                    if (grant_we && d_be == 4'hF) mem_data_in <= d_wdata;
                    if (grant_we && d_be == 4'h0) d_rdata <= rd_reg;
                end
                RD: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (rd_done) begin
                        rd_reg <= mem_data_out;
                        if (lat_we)              mem_data_in <= merge_word(lat_wdata, lat_be, mem_data_out);
                        else if (owner == OWN_D) d_rdata     <= mem_data_out;
                        else                     i_rdata     <= mem_data_out;
                    end
                end
                WR:      d_rdata <= mem_data_in;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level timeline model checking an L=3 instance every
// cycle under random traffic, plus literal directed checks on L=1 and L=3 instances.
module tb_mem_port_arbiter;
    localparam int L = 3;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int n_acks   = 0;

    // Main instance, MEM_LATENCY = L
    logic i_req = 0, d_req = 0, d_we = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic [3:0] d_be = 0;
    logic [31:0] i_rdata, d_rdata, mem_addr;
    logic i_ack, d_ack, mem_write_en, busy;
    logic [0:3][7:0] mem_data_in, mem_data_out;

    // Second instance, MEM_LATENCY = 1
    logic i_req_1 = 0, d_req_1 = 0, d_we_1 = 0;
    logic [31:0] i_addr_1 = 0, d_addr_1 = 0, d_wdata_1 = 0;
    logic [3:0] d_be_1 = 0;
    logic [31:0] i_rdata_1, d_rdata_1, mem_addr_1;
    logic i_ack_1, d_ack_1, mem_write_en_1, busy_1;
    logic [0:3][7:0] mem_data_in_1, mem_data_out_1;

    mem_port_arbiter #(.MEM_LATENCY(L)) dut (
        .clk(clk), .rst_b(rst_b),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_write_en(mem_write_en), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) dut_1 (
        .clk(clk), .rst_b(rst_b),
        .i_req(i_req_1), .i_addr(i_addr_1), .i_rdata(i_rdata_1), .i_ack(i_ack_1),
        .d_req(d_req_1), .d_we(d_we_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1), .d_be(d_be_1),
        .d_rdata(d_rdata_1), .d_ack(d_ack_1),
        .mem_addr(mem_addr_1), .mem_data_in(mem_data_in_1), .mem_data_out(mem_data_out_1),
        .mem_write_en(mem_write_en_1), .busy(busy_1)
    );

    function automatic logic [31:0] seed_word(input int k);
        if (k == 0) return 32'h1122_3344;
        return 32'h9E37_79B9 * 32'(k + 1);
    endfunction

    // Memories: 16 words; main one returns data after L cycles of a stable address.
    logic [31:0] mem [16];
    logic [31:0] mem_1 [16];
    logic [31:0] rd_p1, rd_p2;
    logic mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int k = 0; k < 16; k++) begin
                mem[k]   <= seed_word(k);
                mem_1[k] <= 32'h1122_3344;
            end
            mem_loaded <= 1'b1;
        end else begin
            if (mem_write_en)   mem[mem_addr[5:2]]     <= mem_data_in;
            if (mem_write_en_1) mem_1[mem_addr_1[5:2]] <= mem_data_in_1;
        end
        rd_p1 <= mem[mem_addr[5:2]];
        rd_p2 <= rd_p1;
    end
    assign mem_data_out   = rd_p2;
    assign mem_data_out_1 = mem_1[mem_addr_1[5:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: each grant schedules its busy window, write cycle and ack cycle.
    logic [31:0] ref_mem [16];
    initial begin : compare
        int m_start, m_end, m_wr, m_widx, idx;
        logic m_own_d, last_d, give_d;
        logic [31:0] m_rdata, m_wword, exp_addr, exp_ir, exp_dr, last_read, mask;
        for (int k = 0; k < 16; k++) ref_mem[k] = seed_word(k);
        m_start = 0; m_end = -1; m_wr = -1; m_widx = 0; m_own_d = 0; last_d = 0;
        m_rdata = 0; m_wword = 0; exp_addr = 0; exp_ir = 0; exp_dr = 0; last_read = 0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                check("rst_busy", busy, 0);       check("rst_i_ack", i_ack, 0);
                check("rst_d_ack", d_ack, 0);     check("rst_we", mem_write_en, 0);
                check("rst_mem_addr", mem_addr, 0); check("rst_data_in", mem_data_in, 0);
                check("rst_i_rdata", i_rdata, 0); check("rst_d_rdata", d_rdata, 0);
                m_start = 0; m_end = -1; m_wr = -1; last_d = 0;
                exp_addr = 0; exp_ir = 0; exp_dr = 0; last_read = 0;
                continue;
            end
            if (cyc == m_end) begin
                if (m_own_d) exp_dr = m_rdata;
                else         exp_ir = m_rdata;
            end
            check("busy", busy, (cyc >= m_start) && (cyc <= m_end));
            check("i_ack", i_ack, (cyc == m_end) && !m_own_d);
            check("d_ack", d_ack, (cyc == m_end) && m_own_d);
            check("mem_write_en", mem_write_en, cyc == m_wr);
            check("mem_addr", mem_addr, exp_addr);
            check("i_rdata", i_rdata, exp_ir);
            check("d_rdata", d_rdata, exp_dr);
            if (cyc == m_wr) begin
                check("mem_data_in", mem_data_in, m_wword);
                ref_mem[m_widx] = m_wword;
            end
            if (i_ack || d_ack) n_acks++;
            if (cyc > m_end && (i_req || d_req)) begin
                give_d  = d_req && (!i_req || !last_d);
                last_d  = give_d;
                m_own_d = give_d;
                m_start = cyc + 1;
                m_wr    = -1;
                if (!give_d || !d_we) begin
                    idx      = give_d ? int'(d_addr[5:2]) : int'(i_addr[5:2]);
                    exp_addr = {give_d ? d_addr[31:2] : i_addr[31:2], 2'b00};
                    m_rdata  = ref_mem[idx];
                    last_read = m_rdata;
                    m_end    = cyc + L + 1;
                end else begin
                    idx      = int'(d_addr[5:2]);
                    exp_addr = {d_addr[31:2], 2'b00};
                    m_widx   = idx;
                    if (d_be == 4'hF) begin
                        m_wword = d_wdata; m_rdata = d_wdata;
                        m_wr = cyc + 1; m_end = cyc + 2;
                    end else if (d_be == 4'h0) begin
                        m_rdata = last_read; m_end = cyc + 1;
                    end else begin
                        mask = {{8{d_be[3]}}, {8{d_be[2]}}, {8{d_be[1]}}, {8{d_be[0]}}};
                        last_read = ref_mem[idx];
                        m_wword = (d_wdata & mask) | (last_read & ~mask);
                        m_rdata = m_wword;
                        m_wr = cyc + L + 1; m_end = cyc + L + 2;
                    end
                end
            end
        end
    end

    task automatic fetch_1(input logic [31:0] addr, input logic [31:0] exp_word);
        @(posedge clk); #1; i_req_1 = 1; i_addr_1 = addr;
        @(negedge clk);
        @(negedge clk);
        check("f1_mem_addr", mem_addr_1, addr & 32'hFFFF_FFFC);
        check("f1_ack_early", i_ack_1, 0);
        @(negedge clk);
        check("f1_i_ack", i_ack_1, 1);
        check("f1_i_rdata", i_rdata_1, exp_word);
        check("f1_d_ack", d_ack_1, 0);
        @(posedge clk); #1; i_req_1 = 0;
        @(negedge clk);
        check("f1_ack_pulse", i_ack_1, 0);
    endtask

    initial begin : stim
        int tie_cyc[$];
        logic tie_d[$];
        int exp_tie_cyc[4] = '{2, 5, 8, 11};
        logic exp_tie_d[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic ia, da;

        repeat (3) @(posedge clk);
        #1 rst_b = 1;

        // Tie right after reset on the L=1 instance: D first, then alternate.
        i_req_1 = 1; d_req_1 = 1; d_we_1 = 0; i_addr_1 = 32'h4; d_addr_1 = 32'h8;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (d_ack_1) begin tie_cyc.push_back(c); tie_d.push_back(1'b1); d_addr_1 += 4; end
            if (i_ack_1) begin tie_cyc.push_back(c); tie_d.push_back(1'b0); i_addr_1 += 4; end
        end
        @(posedge clk); #1; i_req_1 = 0; d_req_1 = 0;
        check("tie_ack_count", tie_cyc.size(), 4);
        if (tie_cyc.size() == 4)
            for (int k = 0; k < 4; k++) begin
                check("tie_ack_cycle", tie_cyc[k], exp_tie_cyc[k]);
                check("tie_owner_is_d", tie_d[k], exp_tie_d[k]);
            end

        fetch_1(32'h0000_0013, 32'h1122_3344);

        // Full store; req dropped during the write cycle, ack still due.
        @(posedge clk); #1;
        d_req_1 = 1; d_we_1 = 1; d_addr_1 = 32'h20; d_wdata_1 = 32'hDEAD_BEEF; d_be_1 = 4'hF;
        @(negedge clk);
        check("fs_we_c0", mem_write_en_1, 0);
        @(posedge clk); #1; d_req_1 = 0;
        @(negedge clk);
        check("fs_we_c1", mem_write_en_1, 1);
        check("fs_data", mem_data_in_1, 32'hDEAD_BEEF);
        check("fs_lane0", mem_data_in_1[0], 8'hDE);
        check("fs_lane3", mem_data_in_1[3], 8'hEF);
        @(negedge clk);
        check("fs_we_c2", mem_write_en_1, 0);
        check("fs_d_ack", d_ack_1, 1);
        check("fs_d_rdata", d_rdata_1, 32'hDEAD_BEEF);

        // Null store: ack in cycle 1 with no write.
        @(posedge clk); #1; d_req_1 = 1; d_we_1 = 1; d_be_1 = 4'h0;
        @(negedge clk);
        @(negedge clk);
        check("ns_d_ack", d_ack_1, 1);
        check("ns_we", mem_write_en_1, 0);
        @(posedge clk); #1; d_req_1 = 0;
        @(negedge clk);
        check("ns_idle", busy_1, 0);
        check("ns_we_after", mem_write_en_1, 0);

        fetch_1(32'h0000_0022, 32'hDEAD_BEEF);

        // L=3 partial store of the low byte over 0x11223344.
        @(posedge clk); #1;
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h0000_00AB; d_be = 4'b0001;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 3) begin
                check("ps_busy_rd", busy, 1);
                check("ps_we_rd", mem_write_en, 0);
            end
            if (c == 4) begin
                check("ps_we", mem_write_en, 1);
                check("ps_merged", mem_data_in, 32'h1122_33AB);
            end
            if (c == 5) begin
                check("ps_d_ack", d_ack, 1);
                check("ps_d_rdata", d_rdata, 32'h1122_33AB);
            end
        end
        @(posedge clk); #1; d_req = 0;

        // Reset pulse during the read phase of a partial store.
        @(posedge clk); #1;
        d_req = 1; d_we = 1; d_addr = 32'h104; d_wdata = 32'hFFFF_FFFF; d_be = 4'b0110;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #3; rst_b = 0; d_req = 0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_we", mem_write_en, 0);
        check("ar_d_ack", d_ack, 0);
        check("ar_d_rdata", d_rdata, 0);
        check("ar_mem_addr", mem_addr, 0);
        check("ar_data_in", mem_data_in, 0);
        repeat (2) @(posedge clk);
        #1 rst_b = 1;
        d_req = 1; d_we = 0; d_addr = 32'h104;
        for (int c = 0; c <= L + 1; c++) begin
            @(negedge clk);
            if (c == L) check("ar_fresh_early", d_ack, 0);
            if (c == L + 1) begin
                check("ar_fresh_ack", d_ack, 1);
                check("ar_fresh_rdata", d_rdata, seed_word(1));
            end
        end
        @(posedge clk); #1; d_req = 0;

        // Random traffic on the main instance under the requester protocol.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            ia = i_ack; da = d_ack;
            @(posedge clk); #1;
            if (!i_req || ia) begin
                i_req  = ($urandom_range(0, 3) != 0);
                i_addr = 32'h100 | 32'($urandom_range(0, 63));
            end
            if (!d_req || da) begin
                d_req   = ($urandom_range(0, 3) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 32'h100 | 32'($urandom_range(0, 63));
                d_wdata = $urandom;
                case ($urandom_range(0, 3))
                    0:       d_be = 4'hF;
                    1:       d_be = 4'h0;
                    default: d_be = 4'($urandom_range(1, 14));
                endcase
            end
        end
        @(posedge clk); #1; i_req = 0; d_req = 0;
        repeat (2 * L + 10) @(posedge clk);
        check("random_progress", n_acks > 200, 1);
        check("final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single word-wide, byte-laned data memory port (`mem_addr`, `mem_data_in[0:3]`, `mem_data_out[0:3]`, `mem_write_en`) between an instruction-fetch requester and a load/store requester. Provides round-robin arbitration, fixed-latency read sequencing, and read-modify-write for partial (byte/halfword) stores. The memory has only one write enable, so partial stores need the read-modify-write sequence. Sits between the MIPS core's fetch/LSU logic and a unified memory.

## Interface
- `MEM_LATENCY`, default 1: cycles from `mem_addr` valid to `mem_data_out` valid; legal range 1..15.
- `clk`  in  1  — single clock, rising edge.
- `rst_b`  in  1  — asynchronous, active-low reset.
- `i_req`  in  1  — fetch request; read-only.
- `i_addr`  in  32  — fetch byte address; bits [1:0] ignored.
- `i_rdata`  out  32  — fetched word; valid while `i_ack`=1.
- `i_ack`  out  1  — one-cycle completion pulse for fetch.
- `d_req`  in  1  — load/store request.
- `d_we`  in  1  — 1 = store, 0 = load.
- `d_addr`  in  32  — byte address; bits [1:0] ignored.
- `d_wdata`  in  32  — store data, word-positioned.
- `d_be`  in  4  — store byte enables; `d_be[k]` covers word bits [8k+7:8k]. Ignored for loads.
- `d_rdata`  out  32  — load word; valid while `d_ack`=1.
- `d_ack`  out  1  — one-cycle completion pulse for load/store.
- `mem_addr`  out  32  — word-aligned address: {addr[31:2],2'b00}.
- `mem_data_in`  out  4×8  — write lanes. Lane 0 = word bits [31:24] … lane 3 = bits [7:0]; big-endian.
- `mem_data_out`  in  4×8  — read lanes, same mapping.
- `mem_write_en`  out  1  — write strobe; all four lanes are written.
- `busy`  out  1  — high in any state other than IDLE.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- Arbitration happens only in IDLE.
  - Both requests high: grant the requester not granted last. `last_grant` resets to I, so D wins the first tie.
  - Only one request high: grant it.
  - On grant: latch `owner`, word address, `d_we`, `d_wdata`, `d_be`. Update `last_grant`.
- Next state from IDLE after a grant:
  - Fetch, load, or partial store (`d_be` ∉ {0000,1111}) → RD. Latency counter loads `MEM_LATENCY`.
  - Full store (`d_be`=1111) → WR.
  - Null store (`d_be`=0000) → RESP with no memory access.
- RD:
  - `mem_addr` holds the latched address; counter decrements each cycle.
  - At the edge where the count expires, capture `mem_data_out` into a 32-bit read register.
  - Load/fetch → RESP. Partial store → WR.
- WR, one cycle:
  - `mem_write_en`=1.
  - `mem_data_in` = the merge. Byte k comes from `d_wdata` if `d_be[k]`, else from the read register. Full store uses `d_wdata` only.
  - Next state RESP.
- RESP, one cycle:
  - Owner's ack=1. Owner's rdata = read register; store returns the merged word.
  - Next state IDLE.
- `i_rdata`/`d_rdata` hold their value until that port's next completion.
- Requester protocol:
  - Hold req and operands stable until the ack cycle.
  - Deassert req in the cycle after ack unless issuing a new request.
  - If req drops mid-transaction, the transaction still completes and ack still pulses.
- The non-owner's req is ignored until IDLE; no queueing beyond the req line itself.

## Timing
- Request sampled in IDLE at cycle 0:
  - Load/fetch: RD cycles 1..`MEM_LATENCY`, ack in cycle `MEM_LATENCY`+1.
  - Full store: WR cycle 1, ack cycle 2.
  - Partial store: RD 1..L, WR L+1, ack L+2.
  - Null store: ack cycle 1.
- One IDLE cycle between transactions. Back-to-back loads at L=1: one per 3 cycles.
- `mem_write_en` is asserted only in WR, registered, glitch-free, never two consecutive cycles.
- `mem_addr` is stable from the first RD/WR cycle through RESP. It holds its last value in IDLE.
- Reset, asynchronous, any state:
  - State → IDLE; `last_grant`=I.
  - Outputs cleared: `i_ack`, `d_ack`, `mem_write_en`, `busy` = 0; `i_rdata`, `d_rdata`, `mem_addr` = 0; `mem_data_in` lanes = 8'h00.
  - An in-flight transaction is abandoned with no ack. A write in progress is aborted combinationally with reset assertion.
- First possible grant: the first rising edge after `rst_b` deasserts.

## Test plan
- L=1. Fetch, `i_addr`=0x0000_0013, memory word 0x1122_3344 at 0x10 → `mem_addr`=0x10 in cycle 1; `i_ack`=1, `i_rdata`=0x1122_3344 in cycle 2; `d_ack` stays 0.
- Full store `d_addr`=0x20, `d_wdata`=0xDEAD_BEEF, `d_be`=1111 → `mem_write_en`=1 in cycle 1 only, lanes {DE,AD,BE,EF}; `d_ack` in cycle 2.
- L=3. Partial store `d_be`=0001, `d_wdata`=0x0000_00AB over memory 0x1122_3344 → RD cycles 1–3, WR cycle 4 writes 0x1122_33AB, `d_ack` cycle 5.
- `i_req` and `d_req` both held high for continuous new requests after reset → grant order D,I,D,I. Neither port waits more than one foreign transaction.
- `d_be`=0000 store → `d_ack` in cycle 1; `mem_write_en` never asserted.
- `rst_b` pulsed low during RD of a partial store → no `mem_write_en`, no ack. All outputs at reset values. A fresh request afterwards completes normally.
